// File: rtl/disp_mux_scan.sv
// ---------------------------------------------------------------------------
// disp_mux_scan
//   N-channel display source selector with an auto-scan mode. It sits between
//   the CPU/peripheral data buses and the 7-segment/LED display driver.
//   Channel 0 is a CPU-written shadow register set, captured when EN is high.
//   Channels 1..NCH-1 pass their live bus slices through. The channel is
//   chosen either manually from Test or by an internal dwell timer that steps
//   through all channels. All outputs are registered.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   EN         capture ch0 shadow from data_in/LES/point_in slice 0
//   Test       manual channel select (CW bits)
//   auto_scan  1 = dwell-timer scanning, 0 = manual selection from Test
//   hold       freeze outputs, channel select and dwell timer
//   data_in    channel k data at [k*DW +: DW]
//   LES        channel k blink enables at [k*SW +: SW]
//   point_in   channel k decimal points at [k*SW +: SW]
//   Disp_num   selected data (registered)
//   LE_out     selected blink enables (registered)
//   point_out  selected decimal points (registered)
//   ch_out     channel currently driving the outputs
//   ch_strobe  one-cycle pulse when ch_out changes
// ---------------------------------------------------------------------------
module disp_mux_scan #(
  parameter int              NCH      = 8,
  parameter int              DW       = 32,
  parameter int              SW       = 8,
  parameter int              DWELL    = 25_000_000,
  parameter logic [DW-1:0]   RST_DISP = 32'hAA5555AA,
  localparam int             CW       = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic [CW-1:0]     Test,
  input  logic              auto_scan,
  input  logic              hold,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH*SW-1:0] LES,
  input  logic [NCH*SW-1:0] point_in,
  output logic [DW-1:0]     Disp_num,
  output logic [SW-1:0]     LE_out,
  output logic [SW-1:0]     point_out,
  output logic [CW-1:0]     ch_out,
  output logic              ch_strobe
);

  localparam int              CNTW     = $clog2(DWELL);
  localparam logic [CW:0]     NCH_W    = (CW+1)'(NCH);
  localparam logic [CW-1:0]   LAST_CH  = CW'(NCH - 1);
  localparam logic [CW-1:0]   CH_ZERO  = {CW{1'b0}};
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DWELL - 1);
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};

  // channel 0 shadow registers
  logic [DW-1:0]   d0_q, d0_d;
  logic [SW-1:0]   le0_q, le0_d;
  logic [SW-1:0]   pt0_q, pt0_d;
  // selection / dwell state
  logic [CW-1:0]   sel_q, sel_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            auto_q, auto_d;
  // output registers
  logic [DW-1:0]   disp_q, disp_d;
  logic [SW-1:0]   le_q, le_d;
  logic [SW-1:0]   pt_q, pt_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            stb_q, stb_d;

  logic            test_ok_s;

  // Per-channel views of the flattened buses; index 0 is never selected
  // because channel 0 is served from the shadow registers.
  logic [DW-1:0] data_ch_s [NCH];
  logic [SW-1:0] les_ch_s  [NCH];
  logic [SW-1:0] pt_ch_s   [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_slice
    assign data_ch_s[k] = data_in[k*DW +: DW];
    assign les_ch_s[k]  = LES[k*SW +: SW];
    assign pt_ch_s[k]   = point_in[k*SW +: SW];
  end

  // Test can exceed NCH-1 when NCH is not a power of two
  assign test_ok_s = ({1'b0, Test} < NCH_W);

  // Channel 0 shadow capture, independent of hold, mode and selection
  always_comb begin
    if (EN) begin
      d0_d  = data_in[DW-1:0];
      le0_d = LES[SW-1:0];
      pt0_d = point_in[SW-1:0];
    end else begin
      d0_d  = d0_q;
      le0_d = le0_q;
      pt0_d = pt0_q;
    end
  end

  // Channel select and dwell timer
  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    auto_d = auto_q;
    if (hold) begin
      sel_d  = sel_q;
      cnt_d  = cnt_q;
      auto_d = auto_q;
    end else begin
      // auto_q only advances while not held so a mode entry is never lost
      auto_d = auto_scan;
      if (!auto_scan) begin
        // manual mode (also the cycle after leaving auto): an exit beats a wrap
        cnt_d = CNT_ZERO;
        if (test_ok_s) begin
          sel_d = Test;
        end else begin
          sel_d = sel_q;
        end
      end else if (!auto_q) begin
        // entering auto: start from Test if it names a real channel
        cnt_d = CNT_ZERO;
        sel_d = test_ok_s ? Test : CH_ZERO;
      end else if (cnt_q == LAST_CNT) begin
        cnt_d = CNT_ZERO;
        sel_d = (sel_q == LAST_CH) ? CH_ZERO : sel_q + CW'(1);
      end else begin
        cnt_d = cnt_q + CNTW'(1);
        sel_d = sel_q;
      end
    end
  end

  // Output register next-state: the registered sel drives the mux, giving
  // two clocks from Test and one clock from a live input change
  always_comb begin
    disp_d = disp_q;
    le_d   = le_q;
    pt_d   = pt_q;
    ch_d   = ch_q;
    stb_d  = 1'b0;
    if (hold) begin
      disp_d = disp_q;
      le_d   = le_q;
      pt_d   = pt_q;
      ch_d   = ch_q;
      stb_d  = 1'b0;
    end else begin
      ch_d  = sel_q;
      stb_d = (sel_q != ch_q);
      if (sel_q == CH_ZERO) begin
        disp_d = d0_q;
        le_d   = le0_q;
        pt_d   = pt0_q;
      end else begin
        disp_d = data_ch_s[sel_q];
        le_d   = les_ch_s[sel_q];
        pt_d   = pt_ch_s[sel_q];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_q   <= RST_DISP;
      le0_q  <= {SW{1'b1}};
      pt0_q  <= {SW{1'b0}};
      sel_q  <= CH_ZERO;
      cnt_q  <= CNT_ZERO;
      auto_q <= 1'b0;
      disp_q <= RST_DISP;
      le_q   <= {SW{1'b1}};
      pt_q   <= {SW{1'b0}};
      ch_q   <= CH_ZERO;
      stb_q  <= 1'b0;
    end else begin
      d0_q   <= d0_d;
      le0_q  <= le0_d;
      pt0_q  <= pt0_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      auto_q <= auto_d;
      disp_q <= disp_d;
      le_q   <= le_d;
      pt_q   <= pt_d;
      ch_q   <= ch_d;
      stb_q  <= stb_d;
    end
  end

  assign Disp_num  = disp_q;
  assign LE_out    = le_q;
  assign point_out = pt_q;
  assign ch_out    = ch_q;
  assign ch_strobe = stb_q;

endmodule

// File: tb/tb_disp_mux_scan.sv
module tb_disp_mux_scan;

  localparam int NCH   = 8;
  localparam int NCH5  = 5;
  localparam int DW    = 32;
  localparam int SW    = 8;
  localparam int DWELL = 4;
  localparam logic [31:0] RST_DISP = 32'hAA5555AA;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 8-channel instance
  logic              en;
  logic [2:0]        test;
  logic              auto_scan;
  logic              hold;
  logic [NCH*DW-1:0] data_in;
  logic [NCH*SW-1:0] les;
  logic [NCH*SW-1:0] point_in;
  logic [DW-1:0]     disp;
  logic [SW-1:0]     le_o;
  logic [SW-1:0]     pt_o;
  logic [2:0]        ch_o;
  logic              stb;

  // 5-channel instance
  logic               en5;
  logic [2:0]         test5;
  logic               auto5;
  logic               hold5;
  logic [NCH5*DW-1:0] data5;
  logic [NCH5*SW-1:0] les5;
  logic [NCH5*SW-1:0] pt5;
  logic [DW-1:0]      disp5;
  logic [SW-1:0]      le5_o;
  logic [SW-1:0]      pt5_o;
  logic [2:0]         ch5_o;
  logic               stb5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  disp_mux_scan #(.NCH(NCH), .DW(DW), .SW(SW), .DWELL(DWELL), .RST_DISP(RST_DISP)) dut (
    .clk(clk), .rst(rst), .EN(en), .Test(test), .auto_scan(auto_scan), .hold(hold),
    .data_in(data_in), .LES(les), .point_in(point_in),
    .Disp_num(disp), .LE_out(le_o), .point_out(pt_o), .ch_out(ch_o), .ch_strobe(stb)
  );

  disp_mux_scan #(.NCH(NCH5), .DW(DW), .SW(SW), .DWELL(DWELL), .RST_DISP(RST_DISP)) dut5 (
    .clk(clk), .rst(rst), .EN(en5), .Test(test5), .auto_scan(auto5), .hold(hold5),
    .data_in(data5), .LES(les5), .point_in(pt5),
    .Disp_num(disp5), .LE_out(le5_o), .point_out(pt5_o), .ch_out(ch5_o), .ch_strobe(stb5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model + scoreboard (8-channel instance) -------
  typedef struct packed {
    logic [31:0] disp;
    logic [7:0]  le;
    logic [7:0]  pt;
    logic [2:0]  ch;
    logic        stb;
  } out_t;

  out_t        m_o;
  out_t        exp_q[$];
  logic [31:0] m_d0;
  logic [7:0]  m_le0;
  logic [7:0]  m_pt0;
  logic [2:0]  m_sel;
  int          m_cnt;
  logic        m_auto;

  function automatic out_t model_out();
    out_t o;
    o = m_o;
    if (hold) begin
      o.stb = 1'b0;
    end else begin
      o.ch  = m_sel;
      o.stb = (m_sel != m_o.ch);
      if (m_sel == 3'd0) begin
        o.disp = m_d0;
        o.le   = m_le0;
        o.pt   = m_pt0;
      end else begin
        o.disp = 32'(data_in >> (DW * int'(m_sel)));
        o.le   = 8'(les >> (SW * int'(m_sel)));
        o.pt   = 8'(point_in >> (SW * int'(m_sel)));
      end
    end
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d0   <= RST_DISP;
      m_le0  <= 8'hFF;
      m_pt0  <= 8'h00;
      m_sel  <= 3'd0;
      m_cnt  <= 0;
      m_auto <= 1'b0;
      m_o    <= {RST_DISP, 8'hFF, 8'h00, 3'd0, 1'b0};
      exp_q.delete();
    end else begin
      m_o <= model_out();
      exp_q.push_back(model_out());
      if (en) begin
        m_d0  <= data_in[31:0];
        m_le0 <= les[7:0];
        m_pt0 <= point_in[7:0];
      end
      if (!hold) begin
        m_auto <= auto_scan;
        if (!auto_scan) begin
          m_sel <= test;
          m_cnt <= 0;
        end else if (!m_auto) begin
          m_sel <= test;
          m_cnt <= 0;
        end else if (m_cnt == DWELL - 1) begin
          m_cnt <= 0;
          m_sel <= (m_sel == 3'd7) ? 3'd0 : m_sel + 3'd1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      chk("sb_disp", disp, exp_q[0].disp);
      chk("sb_le", 32'(le_o), 32'(exp_q[0].le));
      chk("sb_pt", 32'(pt_o), 32'(exp_q[0].pt));
      chk("sb_ch", 32'(ch_o), 32'(exp_q[0].ch));
      chk("sb_stb", 32'(stb), 32'(exp_q[0].stb));
      void'(exp_q.pop_front());
    end
  end

  // ---------------- directed stimulus ---------------------------------------
  int          st;
  logic [2:0]  snap_ch;
  logic [31:0] snap_disp;
  bit          found;

  initial begin
    en = 1'b0; test = 3'd0; auto_scan = 1'b0; hold = 1'b0;
    en5 = 1'b0; test5 = 3'd0; auto5 = 1'b0; hold5 = 1'b0;
    for (int k = 0; k < NCH; k++) data_in[k*DW +: DW] = $urandom();
    for (int k = 0; k < NCH5; k++) data5[k*DW +: DW] = $urandom();
    les      = {$urandom(), $urandom()};
    point_in = {$urandom(), $urandom()};
    les5     = 40'({$urandom(), $urandom()});
    pt5      = 40'({$urandom(), $urandom()});

    #2 rst = 1'b1;
    #1;
    chk("rst_disp", disp, RST_DISP);
    chk("rst_le", 32'(le_o), 32'h000000FF);
    chk("rst_pt", 32'(pt_o), 32'h0);
    chk("rst_ch", 32'(ch_o), 32'h0);
    chk("rst_stb", 32'(stb), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // manual select of channel 3: two-clock latency, one strobe
    @(negedge clk);
    data_in[3*DW +: DW] = 32'h12345678;
    test = 3'd3;
    st = 0;
    @(negedge clk);
    st += int'(stb);
    chk("man_lat1", disp, RST_DISP);
    @(negedge clk);
    st += int'(stb);
    chk("man_lat2", disp, 32'h12345678);
    repeat (3) begin
      @(negedge clk);
      st += int'(stb);
    end
    chk("man_strobe_cnt", 32'(st), 32'd1);
    // live change on the selected channel appears after one clock
    data_in[3*DW +: DW] = 32'hCAFEF00D;
    @(negedge clk);
    chk("live_lat1", disp, 32'hCAFEF00D);

    // EN capture into channel 0, then held
    test = 3'd0;
    repeat (2) @(negedge clk);
    data_in[31:0] = 32'hDEADBEEF;
    les[7:0] = 8'h0F;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    data_in[31:0] = 32'h0BADF00D;
    @(negedge clk);
    chk("en_disp", disp, 32'hDEADBEEF);
    chk("en_le", 32'(le_o), 32'h0000000F);
    repeat (3) @(negedge clk);
    chk("en_held", disp, 32'hDEADBEEF);

    // auto wrap from channel 6: 6,7,0,1 each four clocks
    test = 3'd6;
    repeat (3) @(negedge clk);
    auto_scan = 1'b1;
    st = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k <= 17) st += int'(stb);
      if (k == 5) chk("wrap_ch", 32'(ch_o), 32'd6);
      if (k >= 6 && k <= 17) chk("wrap_ch", 32'(ch_o), 32'((7 + (k - 6) / 4) % 8));
    end
    chk("wrap_strobe_cnt", 32'(st), 32'd3);

    // hold for ten clocks in auto mode
    hold = 1'b1;
    snap_ch = ch_o;
    snap_disp = disp;
    st = 0;
    repeat (10) begin
      @(negedge clk);
      st += int'(stb);
    end
    chk("hold_ch", 32'(ch_o), 32'(snap_ch));
    chk("hold_disp", disp, snap_disp);
    chk("hold_strobe_cnt", 32'(st), 32'd0);
    hold = 1'b0;
    repeat (12) @(negedge clk);

    // reset in the middle of a scan while showing channel 5
    auto_scan = 1'b0;
    test = 3'd3;
    repeat (2) @(negedge clk);
    auto_scan = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (ch_o == 3'd5) found = 1'b1;
    end
    chk("reach_ch5", 32'(ch_o), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_disp", disp, RST_DISP);
    chk("mid_rst_le", 32'(le_o), 32'h000000FF);
    chk("mid_rst_pt", 32'(pt_o), 32'h0);
    chk("mid_rst_ch", 32'(ch_o), 32'h0);
    chk("mid_rst_stb", 32'(stb), 32'h0);
    auto_scan = 1'b0;
    test = 3'd0;
    @(negedge clk);
    rst = 1'b0;

    // five-channel instance: out-of-range Test handling
    test5 = 3'd2;
    repeat (3) @(negedge clk);
    chk("n5_man_ch", 32'(ch5_o), 32'd2);
    chk("n5_man_disp", disp5, data5[2*DW +: DW]);
    test5 = 3'd6;
    repeat (3) @(negedge clk);
    chk("n5_oor_ch", 32'(ch5_o), 32'd2);
    test5 = 3'd7;
    auto5 = 1'b1;
    repeat (2) @(negedge clk);
    chk("n5_entry_ch", 32'(ch5_o), 32'd0);
    chk("n5_entry_disp", disp5, RST_DISP);
    chk("n5_entry_stb", 32'(stb5), 32'd1);
    repeat (4) @(negedge clk);
    chk("n5_step_ch", 32'(ch5_o), 32'd1);
    repeat (15) @(negedge clk);
    chk("n5_last_ch", 32'(ch5_o), 32'd4);
    @(negedge clk);
    chk("n5_wrap_ch", 32'(ch5_o), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
